cgra_ctrl_mem_seq: RTL and testbench

//  Per-tile configuration memory and sequencer feeding the crossbar's recv_opt channel.

---
 rtl/cgra_ctrl_mem_seq_if.sv | 54 +++++
 rtl/cgra_ctrl_mem_seq.sv | 158 +++++++++++++++
 tb/tb_cgra_ctrl_mem_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_ctrl_mem_seq_if.sv
// Host/crossbar-facing bundle of the per-tile config memory sequencer.
// perf_stall_cnt is present only when CTRL_MEM_PERF_EN is defined.
interface cgra_ctrl_mem_seq_if #(
    parameter int CFG_W  = 49,
    parameter int ADDR_W = 2,
    parameter int ITER_W = 8
);
    logic              recv_ctrl__en;
    logic [CFG_W-1:0]  recv_ctrl__msg;
    logic [ADDR_W-1:0] recv_waddr__msg;
    logic              recv_ctrl__rdy;
    logic              start__en;
    logic [ADDR_W:0]   start_len__msg;
    logic [ITER_W-1:0] start_iter__msg;
    logic              stop__en;
    logic              send_ctrl__en;
    logic [CFG_W-1:0]  send_ctrl__msg;
    logic              send_ctrl__rdy;
    logic              busy;
    logic              done;
`ifdef CTRL_MEM_PERF_EN
    logic [15:0]       perf_stall_cnt;

    modport master (
        output recv_ctrl__en, recv_ctrl__msg, recv_waddr__msg,
        output start__en, start_len__msg, start_iter__msg, stop__en,
        output send_ctrl__rdy,
        input  recv_ctrl__rdy, send_ctrl__en, send_ctrl__msg, busy, done,
        input  perf_stall_cnt
    );

    modport slave (
        input  recv_ctrl__en, recv_ctrl__msg, recv_waddr__msg,
        input  start__en, start_len__msg, start_iter__msg, stop__en,
        input  send_ctrl__rdy,
        output recv_ctrl__rdy, send_ctrl__en, send_ctrl__msg, busy, done,
        output perf_stall_cnt
    );
`else
    modport master (
        output recv_ctrl__en, recv_ctrl__msg, recv_waddr__msg,
        output start__en, start_len__msg, start_iter__msg, stop__en,
        output send_ctrl__rdy,
        input  recv_ctrl__rdy, send_ctrl__en, send_ctrl__msg, busy, done
    );

    modport slave (
        input  recv_ctrl__en, recv_ctrl__msg, recv_waddr__msg,
        input  start__en, start_len__msg, start_iter__msg, stop__en,
        input  send_ctrl__rdy,
        output recv_ctrl__rdy, send_ctrl__en, send_ctrl__msg, busy, done
    );
`endif
endinterface

// File: rtl/cgra_ctrl_mem_seq.sv
// Per-tile configuration memory and replay sequencer feeding the crossbar recv_opt channel.
// Optional stall counter enabled by defining CTRL_MEM_PERF_EN.
module cgra_ctrl_mem_seq #(
    parameter int CFG_W  = 49,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int ITER_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    cgra_ctrl_mem_seq_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] w_rd_ptr_next;
    logic [ITER_W-1:0] r_iter_cnt;
    logic [ITER_W-1:0] w_iter_cnt_next;
    logic [ADDR_W:0]   r_len_q;
    logic [ADDR_W:0]   w_len_q_next;
    logic [ITER_W-1:0] r_iter_q;
    logic [ITER_W-1:0] w_iter_q_next;
    logic              r_done;
    logic              w_done_next;

    logic              w_idle;
    logic              w_run;
    logic              w_len_ok;
    logic              w_start_ok;
    logic              w_xfer;
    logic              w_last_entry;
    logic              w_finish;
    logic [ITER_W-1:0] w_iter_inc;
    logic [CFG_W-1:0]  w_entry [DEPTH];

    assign w_idle       = (r_state == S_IDLE);
    assign w_run        = (r_state == S_RUN);
    assign w_len_ok     = (bus.start_len__msg != '0) && (bus.start_len__msg <= LEN_MAX);
    assign w_start_ok   = w_idle && bus.start__en && w_len_ok;
    assign w_xfer       = w_run && bus.send_ctrl__rdy;
    // Wrap is at the programmed length, not at the physical depth.
    assign w_last_entry = ({1'b0, r_rd_ptr} == (r_len_q - 1'b1));
    assign w_iter_inc   = r_iter_cnt + 1'b1;
    assign w_finish     = w_xfer && w_last_entry && (r_iter_q != '0) && (w_iter_inc == r_iter_q);

    // Config store: one register per entry so every entry can be cleared by reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            logic             w_wr_en;
            logic [CFG_W-1:0] r_word;

            assign w_wr_en = w_idle && bus.recv_ctrl__en &&
                             (bus.recv_waddr__msg == ADDR_W'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_word <= '0;
                end else if (w_wr_en) begin
                    r_word <= bus.recv_ctrl__msg;
                end
            end

            assign w_entry[gi] = r_word;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rd_ptr   <= '0;
            r_iter_cnt <= '0;
            r_len_q    <= '0;
            r_iter_q   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_iter_cnt <= w_iter_cnt_next;
            r_len_q    <= w_len_q_next;
            r_iter_q   <= w_iter_q_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_rd_ptr_next   = r_rd_ptr;
        w_iter_cnt_next = r_iter_cnt;
        w_len_q_next    = r_len_q;
        w_iter_q_next   = r_iter_q;
        w_done_next     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next    = S_RUN;
                    w_len_q_next    = bus.start_len__msg;
                    w_iter_q_next   = bus.start_iter__msg;
                    w_rd_ptr_next   = '0;
                    w_iter_cnt_next = '0;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    if (w_last_entry) begin
                        w_rd_ptr_next   = '0;
                        w_iter_cnt_next = w_iter_inc;
                    end else begin
                        w_rd_ptr_next   = r_rd_ptr + 1'b1;
                    end
                end
                // A finishing transfer wins over a simultaneous stop so done still pulses.
                if (w_finish) begin
                    w_state_next  = S_IDLE;
                    w_rd_ptr_next = '0;
                    w_done_next   = 1'b1;
                end else if (bus.stop__en) begin
                    w_state_next  = S_IDLE;
                    w_rd_ptr_next = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.recv_ctrl__rdy = w_idle;
    assign bus.busy           = w_run;
    assign bus.done           = r_done;
    assign bus.send_ctrl__en  = w_xfer;
    assign bus.send_ctrl__msg = w_run ? w_entry[r_rd_ptr] : '0;

`ifdef CTRL_MEM_PERF_EN
    logic [15:0] r_perf_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_perf_stall_cnt <= '0;
        end else if (w_run && !bus.send_ctrl__rdy && (r_perf_stall_cnt != 16'hFFFF)) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 16'd1;
        end
    end

    assign bus.perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_cgra_ctrl_mem_seq.sv
// Randomized + directed bench for cgra_ctrl_mem_seq against a transfer-count model.
// Define CTRL_MEM_PERF_EN to also check the stall counter.
module tb_cgra_ctrl_mem_seq;
    localparam int CFG_W  = 49;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int ITER_W = 8;

    logic clk;
    logic reset;

    cgra_ctrl_mem_seq_if #(.CFG_W(CFG_W), .ADDR_W(ADDR_W), .ITER_W(ITER_W)) bus ();

    cgra_ctrl_mem_seq #(
        .CFG_W (CFG_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .ITER_W(ITER_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run is "k transfers so far"; entry k mod len is on the bus,
    // and the run ends once k reaches len*iter (iter != 0).
    logic [CFG_W-1:0] m_mem [DEPTH];
    bit               m_run;
    int               m_len;
    int               m_iter;
    int               m_k;
    bit               m_done_pending;
    int               m_stall;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_en",   {63'd0, bus.send_ctrl__en}, 64'd0);
            chk("rst_msg",  64'(bus.send_ctrl__msg), 64'd0);
            chk("rst_rdy",  {63'd0, bus.recv_ctrl__rdy}, 64'd1);
            chk("rst_busy", {63'd0, bus.busy}, 64'd0);
            chk("rst_done", {63'd0, bus.done}, 64'd0);
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_run = 0; m_len = 0; m_iter = 0; m_k = 0;
            m_done_pending = 0; m_stall = 0;
        end else begin
            chk("busy", {63'd0, bus.busy}, {63'd0, m_run});
            chk("rdy",  {63'd0, bus.recv_ctrl__rdy}, {63'd0, !m_run});
            chk("en",   {63'd0, bus.send_ctrl__en}, {63'd0, m_run && bus.send_ctrl__rdy});
            chk("msg",  64'(bus.send_ctrl__msg), m_run ? 64'(m_mem[m_k % m_len]) : 64'd0);
            chk("done", {63'd0, bus.done}, {63'd0, m_done_pending});
`ifdef CTRL_MEM_PERF_EN
            chk("perf", 64'(bus.perf_stall_cnt), 64'(m_stall));
`endif
            m_done_pending = 0;
            if (!m_run) begin
                if (bus.recv_ctrl__en) m_mem[bus.recv_waddr__msg] = bus.recv_ctrl__msg;
                if (bus.start__en && bus.start_len__msg >= 1 && bus.start_len__msg <= DEPTH) begin
                    m_run  = 1;
                    m_len  = int'(bus.start_len__msg);
                    m_iter = int'(bus.start_iter__msg);
                    m_k    = 0;
                    m_stall = 0;
                end
            end else begin
                if (!bus.send_ctrl__rdy && m_stall < 65535) m_stall++;
                if (bus.send_ctrl__rdy) m_k++;
                if (bus.send_ctrl__rdy && m_iter != 0 && m_k == m_len * m_iter) begin
                    m_run = 0;
                    m_done_pending = 1;
                end else if (bus.stop__en) begin
                    m_run = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.recv_ctrl__en   = 1'b0;
        bus.recv_ctrl__msg  = '0;
        bus.recv_waddr__msg = '0;
        bus.start__en       = 1'b0;
        bus.start_len__msg  = '0;
        bus.start_iter__msg = '0;
        bus.stop__en        = 1'b0;
        bus.send_ctrl__rdy  = 1'b0;
    endtask

    task automatic start(input int len, input int iter);
        bus.start__en       = 1'b1;
        bus.start_len__msg  = (ADDR_W+1)'(len);
        bus.start_iter__msg = ITER_W'(iter);
        step();
        bus.start__en       = 1'b0;
    endtask

    logic [CFG_W-1:0] pat [4];
    logic [CFG_W-1:0] word_e;
    int               rp [5];
    int               ri [5];

    initial begin
        pat[0] = 49'h0_AAAA_0000_0001;
        pat[1] = 49'h1_BBBB_0000_0002;
        pat[2] = 49'h0_CCCC_0000_0003;
        pat[3] = 49'h1_DDDD_0000_0004;
        word_e = 49'h1_EEEE_1234_5678;
        rp = '{1, 0, 0, 1, 1};
        ri = '{0, 1, 1, 1, 2};

        // T1: reset held with random inputs
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.recv_ctrl__en   = 1'($urandom);
            bus.recv_ctrl__msg  = CFG_W'({$urandom(), $urandom()});
            bus.recv_waddr__msg = ADDR_W'($urandom);
            bus.start__en       = 1'($urandom);
            bus.start_len__msg  = (ADDR_W+1)'($urandom);
            bus.start_iter__msg = ITER_W'($urandom);
            bus.stop__en        = 1'($urandom);
            bus.send_ctrl__rdy  = 1'($urandom);
            step();
        end
        clear_inputs();
        reset = 1'b1;
        step();

        // T2: load four entries, replay twice with rdy=1
        for (int i = 0; i < 4; i++) begin
            bus.recv_ctrl__en   = 1'b1;
            bus.recv_waddr__msg = ADDR_W'(i);
            bus.recv_ctrl__msg  = pat[i];
            step();
        end
        bus.recv_ctrl__en  = 1'b0;
        bus.send_ctrl__rdy = 1'b1;
        start(4, 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_msg", 64'(bus.send_ctrl__msg), 64'(pat[i % 4]));
            chk("t2_en", {63'd0, bus.send_ctrl__en}, 64'd1);
            step();
        end
        @(negedge clk);
        chk("t2_done", {63'd0, bus.done}, 64'd1);
        chk("t2_busy", {63'd0, bus.busy}, 64'd0);
        step();

        // T3: len=3 with backpressure
        start(3, 1);
        for (int i = 0; i < 5; i++) begin
            bus.send_ctrl__rdy = 1'(rp[i]);
            @(negedge clk);
            chk("t3_msg", 64'(bus.send_ctrl__msg), 64'(pat[ri[i]]));
            chk("t3_en", {63'd0, bus.send_ctrl__en}, 64'(rp[i]));
            step();
        end
        @(negedge clk);
        chk("t3_done", {63'd0, bus.done}, 64'd1);
`ifdef CTRL_MEM_PERF_EN
        chk("t3_perf", 64'(bus.perf_stall_cnt), 64'd2);
`endif
        step();

        // T4: infinite run stopped on the 6th transfer, then restart
        bus.send_ctrl__rdy = 1'b1;
        start(4, 0);
        for (int i = 0; i < 6; i++) begin
            bus.stop__en = (i == 5);
            @(negedge clk);
            chk("t4_msg", 64'(bus.send_ctrl__msg), 64'(pat[i % 4]));
            step();
        end
        bus.stop__en = 1'b0;
        @(negedge clk);
        chk("t4_busy", {63'd0, bus.busy}, 64'd0);
        chk("t4_done", {63'd0, bus.done}, 64'd0);
        step();
        start(4, 1);
        @(negedge clk);
        chk("t4_restart", 64'(bus.send_ctrl__msg), 64'(pat[0]));
        for (int i = 0; i < 4; i++) step();

        // T5: illegal starts, write and start during RUN are ignored
        start(0, 1);
        @(negedge clk);
        chk("t5_len0", {63'd0, bus.busy}, 64'd0);
        step();
        start(5, 1);
        @(negedge clk);
        chk("t5_len5", {63'd0, bus.busy}, 64'd0);
        step();
        bus.send_ctrl__rdy = 1'b0;
        start(2, 1);
        bus.recv_ctrl__en   = 1'b1;
        bus.recv_waddr__msg = '0;
        bus.recv_ctrl__msg  = '1;
        bus.start__en       = 1'b1;
        bus.start_len__msg  = 3'd1;
        step();
        bus.recv_ctrl__en  = 1'b0;
        bus.start__en      = 1'b0;
        bus.send_ctrl__rdy = 1'b1;
        step();
        step();
        step();
        start(1, 1);
        @(negedge clk);
        chk("t5_mem0", 64'(bus.send_ctrl__msg), 64'(pat[0]));
        step();
        step();

        // T6: write + start in one cycle, then async reset mid-run
        bus.recv_ctrl__en   = 1'b1;
        bus.recv_waddr__msg = '0;
        bus.recv_ctrl__msg  = word_e;
        start(1, 3);
        bus.recv_ctrl__en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_msg", 64'(bus.send_ctrl__msg), 64'(word_e));
            step();
        end
        @(negedge clk);
        chk("t6_done", {63'd0, bus.done}, 64'd1);
        step();
        start(4, 0);
        step();
        reset = 1'b0;
        #1;
        chk("t6_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("t6_rst_en", {63'd0, bus.send_ctrl__en}, 64'd0);
        chk("t6_rst_msg", 64'(bus.send_ctrl__msg), 64'd0);
        chk("t6_rst_rdy", {63'd0, bus.recv_ctrl__rdy}, 64'd1);
        step();
        step();
        reset = 1'b1;
        clear_inputs();
        step();

        // Random traffic, checked every cycle by the model
        for (int c = 0; c < 600; c++) begin
            bus.recv_ctrl__en   = ($urandom_range(0, 99) < 30);
            bus.recv_waddr__msg = ADDR_W'($urandom);
            bus.recv_ctrl__msg  = CFG_W'({$urandom(), $urandom()});
            bus.start__en       = ($urandom_range(0, 99) < 15);
            bus.start_len__msg  = (ADDR_W+1)'($urandom_range(0, 5));
            bus.start_iter__msg = ITER_W'($urandom_range(0, 3));
            bus.stop__en        = ($urandom_range(0, 99) < 5);
            bus.send_ctrl__rdy  = ($urandom_range(0, 99) < 70);
            step();
        end
        clear_inputs();
        step();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
